// File: rtl/pc_predict_unit_pkg.sv
// Shared types and helpers for the fetch-stage PC predictor.
package pc_predict_unit_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    if (up) begin
      return (c == CtrSt) ? c : c + 2'd1;
    end
    return (c == CtrSnt) ? c : c - 2'd1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch/execute signals of the PC predictor. The master side is the pipeline.
interface pc_predict_unit_if #(
  parameter int unsigned SIZE = 32
);
  logic            stallF;
  logic [SIZE-1:0] pc;
  logic [SIZE-1:0] pred_next;
  logic            pred_taken;
  logic            ex_valid;
  logic [SIZE-1:0] ex_pc;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_taken;
  logic [SIZE-1:0] ex_target;
  logic [SIZE-1:0] ex_pred_next;
  logic            mispredict;

  modport master (
    output stallF, ex_valid, ex_pc, ex_branch, ex_jump, ex_taken, ex_target, ex_pred_next,
    input  pc, pred_next, pred_taken, mispredict
  );

  modport slave (
    input  stallF, ex_valid, ex_pc, ex_branch, ex_jump, ex_taken, ex_target, ex_pred_next,
    output pc, pred_next, pred_taken, mispredict
  );
endinterface

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped BTB storage: one combinational lookup port and one synchronous
// update port that applies the allocate/train rules to the addressed entry.
module pc_predict_unit_btb_table
  import pc_predict_unit_pkg::*;
#(
  parameter  int unsigned SIZE    = 32,
  parameter  int unsigned ENTRIES = 16,
  localparam int unsigned IdxW    = idx_w(ENTRIES),
  localparam int unsigned TagW    = SIZE - IdxW - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IdxW-1:0] rd_idx,
  input  logic [TagW-1:0] rd_tag,
  output logic            rd_hit,
  output logic            rd_taken,
  output logic [SIZE-1:0] rd_tgt,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  logic [TagW-1:0] wr_tag,
  input  logic [SIZE-1:0] wr_tgt,
  input  logic            wr_jump,
  input  logic            wr_taken
);

  logic [ENTRIES-1:0]       valid_q;
  logic [ENTRIES-1:0][1:0]  ctr_q;
  logic [TagW-1:0]          tag_q [ENTRIES];
  logic [SIZE-1:0]          tgt_q [ENTRIES];
  logic                     wr_hit;
  logic [1:0]               ctr_d;

  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken = ctr_q[rd_idx][1];
  assign rd_tgt   = tgt_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    ctr_d = CtrWnt;
    if (wr_jump) begin
      ctr_d = CtrSt;
    end else if (!wr_hit) begin
      ctr_d = wr_taken ? CtrWt : CtrWnt;
    end else begin
      ctr_d = ctr_sat(ctr_q[wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{CtrWnt}};
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= ctr_d;
    end
  end

  // Tag and target need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_tgt;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-driven next-PC prediction and execute-stage redirect.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int unsigned     SIZE        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [SIZE-1:0] RESET_PC    = '0
) (
  input logic              clk,
  input logic              rst,
  pc_predict_unit_if.slave bus
);

  localparam int unsigned IdxW = idx_w(BTB_ENTRIES);
  localparam int unsigned TagW = SIZE - IdxW - 2;

  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] pc_plus4, rd_tgt, correct_next;
  logic            rd_hit, rd_taken, pred_taken, actual_taken, mispredict, upd_en;

  pc_predict_unit_btb_table #(
    .SIZE    (SIZE),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_q[IdxW+1:2]),
    .rd_tag   (pc_q[SIZE-1:IdxW+2]),
    .rd_hit   (rd_hit),
    .rd_taken (rd_taken),
    .rd_tgt   (rd_tgt),
    .wr_en    (upd_en),
    .wr_idx   (bus.ex_pc[IdxW+1:2]),
    .wr_tag   (bus.ex_pc[SIZE-1:IdxW+2]),
    .wr_tgt   (bus.ex_target),
    .wr_jump  (bus.ex_jump),
    .wr_taken (bus.ex_taken)
  );

  assign pc_plus4   = pc_q + SIZE'(32'd4);
  assign pred_taken = rd_hit & rd_taken;

  // Every valid instruction is checked, so stale hits on non-branches get corrected too.
  assign actual_taken = bus.ex_jump | (bus.ex_branch & bus.ex_taken);
  assign correct_next = actual_taken ? bus.ex_target : bus.ex_pc + SIZE'(32'd4);
  assign mispredict   = bus.ex_valid & (correct_next != bus.ex_pred_next);
  assign upd_en       = bus.ex_valid & (bus.ex_branch | bus.ex_jump);

  always_comb begin
    pc_d = pred_taken ? rd_tgt : pc_plus4;
    if (mispredict) begin
      pc_d = correct_next;
    end else if (bus.stallF) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pred_taken = pred_taken;
  assign bus.pred_next  = pred_taken ? rd_tgt : pc_plus4;
  assign bus.mispredict = mispredict;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed scoreboard bench for pc_predict_unit (RESET_PC=0x100, 16-entry BTB).
module tb_pc_predict_unit;

  localparam int unsigned SIZE = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_predict_unit_if #(.SIZE(SIZE)) bus ();

  pc_predict_unit #(
    .SIZE        (SIZE),
    .BTB_ENTRIES (16),
    .RESET_PC    (32'h100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic [31:0] pn;
    logic        pt;
    logic        mp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  task automatic chk(input string name, input int s, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s got %h want %h", s, name, got, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected during that cycle.
  task automatic step(input logic st, input logic ev, input logic [31:0] epc,
                      input logic br, input logic jp, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] epn,
                      input logic [31:0] xpc, input logic [31:0] xpn,
                      input logic xpt, input logic xmp);
    exp_t e;
    bus.stallF       = st;
    bus.ex_valid     = ev;
    bus.ex_pc        = epc;
    bus.ex_branch    = br;
    bus.ex_jump      = jp;
    bus.ex_taken     = tk;
    bus.ex_target    = tgt;
    bus.ex_pred_next = epn;
    e.step = step_no;
    e.pc   = xpc;
    e.pn   = xpn;
    e.pt   = xpt;
    e.mp   = xmp;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st, input logic [31:0] xpc, input logic [31:0] xpn,
                      input logic xpt);
    step(st, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, xpc, xpn, xpt, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("pc", mon_e.step, bus.pc, mon_e.pc);
      chk("pred_next", mon_e.step, bus.pred_next, mon_e.pn);
      chk("pred_taken", mon_e.step, {31'd0, bus.pred_taken}, {31'd0, mon_e.pt});
      chk("mispredict", mon_e.step, {31'd0, bus.mispredict}, {31'd0, mon_e.mp});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.stallF = 1'b0; bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_branch = 1'b0;
    bus.ex_jump = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = '0; bus.ex_pred_next = '0;
    repeat (2) @(posedge clk);
    #1;
    idle(1'b0, 32'h100, 32'h104, 1'b0);  // under reset
    rst = 1'b0;
    idle(1'b0, 32'h100, 32'h104, 1'b0);
    idle(1'b0, 32'h104, 32'h108, 1'b0);
    idle(1'b0, 32'h108, 32'h10C, 1'b0);
    // branch 0x108 taken to 0x100, predicted fall-through: allocate ctr=10
    step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h100, 32'h10C, 32'h10C, 32'h110, 1'b0, 1'b1);
    idle(1'b0, 32'h100, 32'h104, 1'b0);
    idle(1'b0, 32'h104, 32'h108, 1'b0);
    idle(1'b0, 32'h108, 32'h100, 1'b1);
    // not taken while predicted taken: ctr 10->01
    step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 32'h100, 32'h100, 32'h100, 32'h104, 1'b0, 1'b1);
    // not taken, predicted fall-through: ctr 01->00, no redirect
    step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 32'h100, 32'h10C, 32'h10C, 32'h110, 1'b0, 1'b0);
    // taken: ctr 00->01, still predicts not taken afterwards
    step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h100, 32'h10C, 32'h110, 32'h114, 1'b0, 1'b1);
    idle(1'b0, 32'h100, 32'h104, 1'b0);
    idle(1'b0, 32'h104, 32'h108, 1'b0);
    // stall at 0x108 with same-index update (01->10); lookup sees old counter
    step(1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 32'h108, 32'h10C, 1'b0, 1'b0);
    idle(1'b1, 32'h108, 32'h100, 1'b1);
    // stall plus mispredict: cold jump 0x200->0x400 redirects anyway
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h400, 32'h204, 32'h108, 32'h100, 1'b1, 1'b1);
    idle(1'b0, 32'h400, 32'h404, 1'b0);  // same idx as 0x200, different tag
    // non-branch with wrong pred_next redirects to 0x148; ex_taken ignored
    step(1'b0, 1'b1, 32'h144, 1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'h404, 32'h408, 1'b0, 1'b1);
    // 0x148 aliases 0x108: miss; then redirect to 0x200
    step(1'b0, 1'b1, 32'h1FC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h148, 32'h14C, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h400, 32'h400, 32'h200, 32'h400, 1'b1, 1'b0);
    idle(1'b0, 32'h400, 32'h404, 1'b0);
    // ex_valid low: mismatching fields must not redirect
    step(1'b0, 1'b0, 32'h500, 1'b1, 1'b0, 1'b1, 32'h600, 32'h0, 32'h404, 32'h408, 1'b0, 1'b0);
    idle(1'b0, 32'h408, 32'h40C, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It generalises the existing PC select logic (pc_plus4 / pc_target / Jump / Branch / stallF) from a static not-taken policy to dynamic prediction. It resolves mispredictions reported by execute and redirects the PC. It sits between the instruction memory address port and the decode stage.

Parameters:
SIZE, 32, PC and target width in bits
BTB_ENTRIES, 16, BTB depth; power of two, >= 2; IDX_W = log2(BTB_ENTRIES)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stallF  in  1  hold the fetch PC
pc  out  SIZE  current fetch PC (registered)
pred_next  out  SIZE  predicted next PC for the instruction at pc; pipelined down to execute
pred_taken  out  1  BTB hit and predicted taken for pc
ex_valid  in  1  execute-stage instruction is valid
ex_pc  in  SIZE  PC of the execute-stage instruction
ex_branch  in  1  execute instruction is a conditional branch
ex_jump  in  1  execute instruction is an unconditional jump
ex_taken  in  1  branch condition result (FU_result bit 0); ignored unless ex_branch
ex_target  in  SIZE  resolved target address
ex_pred_next  in  SIZE  pred_next that travelled with the execute instruction
mispredict  out  1  redirect/flush request to the pipeline (PCSE successor)

Behaviour:
- Reset (async): pc = RESET_PC; all BTB valid = 0; all counters = 2'b01 (weak not-taken); mispredict/pred_taken outputs follow from the reset state.
- Lookup (combinational on pc): idx = pc[IDX_W+1:2], tag = pc[SIZE-1:IDX_W+2]. hit = valid[idx] & (tag_mem[idx] == tag). pred_taken = hit & ctr[idx][1]. pred_next = pred_taken ? tgt_mem[idx] : pc + 4 (modulo 2^SIZE).
- Resolution (combinational): actual_taken = ex_jump | (ex_branch & ex_taken). correct_next = actual_taken ? ex_target : ex_pc + 4. mispredict = ex_valid & (correct_next != ex_pred_next). Applies to every valid instruction, so stale or aliased hits on non-branches are also corrected.
- Next-PC priority on the clock edge: mispredict -> pc = correct_next (overrides stallF); else stallF -> pc held; else pc = pred_next.
- BTB update, only when ex_valid & (ex_branch | ex_jump), independent of stallF:
  - Entry at ex_pc index is a miss (invalid or tag mismatch): write valid = 1, tag, target = ex_target. Counter = 2'b11 for a jump, 2'b10 for a taken branch, 2'b01 for a not-taken branch.
  - Entry is a hit: target = ex_target. Counter = 2'b11 for a jump; for a branch, saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00).
  - Non-branch instructions never write the BTB.
- Same-cycle lookup and update on the same index: lookup sees the pre-update contents; the write is visible from the next cycle.
- Latency: prediction is 0-cycle (same cycle as pc). Redirect takes effect 1 cycle after mispredict is asserted.
- Reset mid-operation: all state is cleared immediately and any pending update is lost.

Decomposition:
- Shared package: 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the saturating inc/dec function; the IDX_W derivation as a constant function.
- Sub-module btb_table: valid/tag/target/counter arrays, one combinational read port and one synchronous write port with async reset of valid and counters. pc_predict_unit holds the PC register, next-PC mux and mispredict logic.

Test Plan:
- Reset with RESET_PC=0x100, stallF=0, no ex_valid for 3 cycles -> pc = 0x100, 0x104, 0x108; pred_taken = 0.
- Branch at 0x108 resolves ex_taken=1, ex_target=0x100, ex_pred_next=0x10C -> mispredict=1; next pc = 0x100; entry allocated with ctr=10. On the next fetch of 0x108: pred_taken=1, pred_next=0x100.
- Same branch is then not taken once (ex_pred_next=0x100) -> mispredict=1, pc = 0x10C, ctr=01. A second not-taken -> ctr=00, with no mispredict when ex_pred_next=0x10C.
- stallF=1 and mispredict in the same cycle -> pc loads correct_next. stallF=1 alone -> pc holds for 2 cycles.
- Aliasing with BTB_ENTRIES=16: a branch at 0x108 is allocated, then fetch 0x148 (same idx, different tag) -> hit=0, pred_next=0x14C.
- Jump at 0x200 to 0x400 on a cold BTB -> mispredict, ctr=11. A later fetch of 0x200 -> pred_next=0x400; resolution with ex_pred_next=0x400 -> mispredict=0.
